// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag layout for the 4-bit accumulator ALU.
package alu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_ADC  = 4'h9;
    localparam logic [3:0] OP_SBC  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_CLR  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bit positions inside the 4-bit flag nibble (uo_out[7:4]).
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    localparam int SYNC_STAGES = 3;

    function automatic logic [3:0] pack_flags(input logic c, input logic z,
                                              input logic n, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul4.sv
// 4x4 unsigned shift-add multiplier, one multiplier bit per cycle.
module alu_mul4
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       done,
    output logic [7:0] product
);

    logic [7:0] mcand_sh;
    logic [7:0] prod;
    logic [7:0] prod_nxt;
    logic [3:0] mplier;
    logic [1:0] cnt;
    logic       running;

    assign prod_nxt = prod + (mplier[0] ? mcand_sh : 8'd0);

    // The final partial sum is offered combinationally so the caller can
    // register the product on the same edge that ends the last iteration.
    assign done    = running && (cnt == 2'd3);
    assign product = prod_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_sh <= '0;
            prod     <= '0;
            mplier   <= '0;
            cnt      <= '0;
            running  <= 1'b0;
        end else if (start) begin
            mcand_sh <= {4'd0, a};
            prod     <= '0;
            mplier   <= b;
            cnt      <= '0;
            running  <= 1'b1;
        end else if (running) begin
            prod     <= prod_nxt;
            mcand_sh <= {mcand_sh[6:0], 1'b0};
            mplier   <= {1'b0, mplier[3:1]};
            cnt      <= cnt + 2'd1;
            if (cnt == 2'd3) running <= 1'b0;
        end
    end

endmodule

// File: rtl/tt_um_4_bit_alu_exec.sv
// Strobe-driven 4-bit accumulator ALU: synchronizer, control FSM and datapath.
module tt_um_4_bit_alu_exec
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t     state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic       accept;
    logic [3:0] op_q, imm_q;
    logic [3:0] acc_q, mul_hi_q, flags_q;
    logic       busy, done;
    logic       mul_start, mul_done;
    logic [7:0] mul_prod;
    logic [3:0] res;
    logic       res_c, res_v, res_upd;
    logic [4:0] u5, s5;
    logic       unused_ok;

    assign unused_ok = &{ena, uio_in[7:1]};

    // vld_pipe marks which sync stages hold real post-reset samples, so a
    // strobe already high at reset release never looks like a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            vld_pipe <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], uio_in[0]};
            vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign accept = sync_q[1] && !sync_q[2] && vld_pipe[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = (op_q == OP_MUL) ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mul_start = (state_q == ST_EXEC) && (op_q == OP_MUL);

    alu_mul4 u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (acc_q),
        .b       (imm_q),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle ops; u5 is the unsigned 5-bit result (carry/borrow in
    // bit 4), s5 the sign-extended one used for overflow.
    always_comb begin
        res     = acc_q;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_upd = 1'b1;
        u5      = '0;
        s5      = '0;
        case (op_q)
            OP_LOAD: res = imm_q;
            OP_ADD, OP_ADC: begin
                u5    = {1'b0, acc_q} + {1'b0, imm_q}
                      + {4'd0, (op_q == OP_ADC) & flags_q[FLAG_C]};
                s5    = {acc_q[3], acc_q} + {imm_q[3], imm_q}
                      + {4'd0, (op_q == OP_ADC) & flags_q[FLAG_C]};
                res   = u5[3:0];
                res_c = u5[4];
                res_v = s5[4] ^ s5[3];
            end
            OP_SUB, OP_SBC: begin
                u5    = {1'b0, acc_q} - {1'b0, imm_q}
                      - {4'd0, (op_q == OP_SBC) & !flags_q[FLAG_C]};
                s5    = {acc_q[3], acc_q} - {imm_q[3], imm_q}
                      - {4'd0, (op_q == OP_SBC) & !flags_q[FLAG_C]};
                res   = u5[3:0];
                res_c = !u5[4];
                res_v = s5[4] ^ s5[3];
            end
            OP_AND:  res = acc_q & imm_q;
            OP_OR:   res = acc_q | imm_q;
            OP_XOR:  res = acc_q ^ imm_q;
            OP_SHL: begin
                res   = {acc_q[2:0], 1'b0};
                res_c = acc_q[3];
            end
            OP_SHR: begin
                res   = {1'b0, acc_q[3:1]};
                res_c = acc_q[0];
            end
            OP_CLR:  res = 4'd0;
            default: res_upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            imm_q    <= '0;
            acc_q    <= '0;
            mul_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            if (state_q == ST_IDLE && accept) begin
                op_q  <= ui_in[7:4];
                imm_q <= ui_in[3:0];
            end
            if (state_q == ST_EXEC && res_upd) begin
                acc_q   <= res;
                flags_q <= pack_flags(res_c, res == 4'd0, res[3], res_v);
                if (op_q == OP_CLR) mul_hi_q <= 4'd0;
            end
            if (state_q == ST_MUL && mul_done) begin
                acc_q    <= mul_prod[3:0];
                mul_hi_q <= mul_prod[7:4];
                flags_q  <= pack_flags(mul_prod[7:4] != 4'd0, mul_prod[3:0] == 4'd0,
                                       mul_prod[3], 1'b0);
            end
        end
    end

    assign uo_out  = {flags_q, acc_q};
    assign uio_out = {mul_hi_q, 1'b0, done, busy, 1'b0};
    assign uio_oe  = 8'hF6;

endmodule

// File: tb/tb_tt_um_4_bit_alu_exec.sv
// Scoreboard bench for the strobe-driven 4-bit ALU.
module tb_tt_um_4_bit_alu_exec;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_4_bit_alu_exec dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int m_acc = 0, m_hi = 0, m_c = 0, m_z = 0, m_n = 0, m_v = 0;

    function automatic int sx(input int x);
        return (x > 7) ? x - 16 : x;
    endfunction

    // Reference behaviour in plain integer arithmetic.
    task automatic model_step(input int op, input int imm);
        int r, t, s, c, v, cin;
        bit upd;
        upd = 1; r = 0; c = 0; v = 0; t = 0; s = 0; cin = 0;
        case (op)
            1: r = imm;
            2, 9: begin
                cin = (op == 9) ? m_c : 0;
                t = m_acc + imm + cin; r = t % 16; c = (t > 15) ? 1 : 0;
                s = sx(m_acc) + sx(imm) + cin; v = (s > 7 || s < -8) ? 1 : 0;
            end
            3, 10: begin
                cin = (op == 10) ? 1 - m_c : 0;
                t = m_acc - imm - cin; r = (t + 16) % 16; c = (t >= 0) ? 1 : 0;
                s = sx(m_acc) - sx(imm) - cin; v = (s > 7 || s < -8) ? 1 : 0;
            end
            4: r = m_acc & imm;
            5: r = m_acc | imm;
            6: r = m_acc ^ imm;
            7: begin r = (m_acc * 2) % 16; c = m_acc / 8; end
            8: begin r = m_acc / 2; c = m_acc % 2; end
            11: begin t = m_acc * imm; r = t % 16; m_hi = t / 16; c = (m_hi != 0) ? 1 : 0; end
            12: begin r = 0; m_hi = 0; end
            default: upd = 0;
        endcase
        if (upd) begin
            m_acc = r; m_c = c; m_v = v;
            m_z = (r == 0) ? 1 : 0;
            m_n = (r >= 8) ? 1 : 0;
        end
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [3:0] imm, input bit retrigger);
        exp_t e;
        int lat, dones;
        logic exp_busy, exp_done;
        model_step(int'(op), int'(imm));
        e.uo  = {m_c[0], m_z[0], m_n[0], m_v[0], m_acc[3:0]};
        e.uio = {m_hi[3:0], 4'b0110};
        sb.push_back(e);
        lat = (op == 4'hB) ? 6 : 2;
        dones = 0;
        @(negedge clk);
        ui_in = {op, imm};
        uio_in[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); @(negedge clk);
            exp_busy = (k >= 3 && k <= 2 + lat);
            exp_done = (k == 2 + lat);
            vectors++;
            if (uio_out[1] !== exp_busy) begin
                miscompares++;
                $display("FAIL busy op=%h k=%0d: got %b expected %b", op, k, uio_out[1], exp_busy);
            end
            vectors++;
            if (uio_out[2] !== exp_done) begin
                miscompares++;
                $display("FAIL done op=%h k=%0d: got %b expected %b", op, k, uio_out[2], exp_done);
            end
            if (uio_out[2] === 1'b1) begin
                dones++;
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL extra_done op=%h k=%0d: got done with no pending result", op, k);
                end else begin
                    e = sb.pop_front();
                    vectors++;
                    if (uo_out !== e.uo || uio_out !== e.uio) begin
                        miscompares++;
                        $display("FAIL result op=%h imm=%h: got uo=%h uio=%h expected uo=%h uio=%h",
                                 op, imm, uo_out, uio_out, e.uo, e.uio);
                    end
                end
            end
            if (k == 3) begin
                uio_in[0] = 1'b0;
                ui_in = 8'($urandom);
            end
            if (retrigger && k == 4) uio_in[0] = 1'b1;
            if (retrigger && k == 7) uio_in[0] = 1'b0;
        end
        vectors++;
        if (sb.size() != 0 || dones != 1) begin
            miscompares++;
            $display("FAIL done_count op=%h: got %0d pulses expected 1 (pending %0d)", op, dones, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hF6) begin
            miscompares++;
            $display("FAIL reset_state: got uo=%h uio=%h oe=%h expected 00 00 f6", uo_out, uio_out, uio_oe);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_add();
        run_cmd(4'h1, 4'h5, 0);
        run_cmd(4'h2, 4'h4, 0);
        vectors++;
        if (uo_out !== 8'h39) begin
            miscompares++;
            $display("FAIL add_flags: got %h expected 39", uo_out);
        end
    endtask

    task automatic test_sub_sbc();
        run_cmd(4'h1, 4'h3, 0);
        run_cmd(4'h3, 4'h3, 0);
        vectors++;
        if (uo_out !== 8'hC0) begin
            miscompares++;
            $display("FAIL sub_zero: got %h expected c0", uo_out);
        end
        run_cmd(4'hA, 4'h1, 0);
        vectors++;
        if (uo_out !== 8'h2F) begin
            miscompares++;
            $display("FAIL sbc_wrap: got %h expected 2f", uo_out);
        end
    endtask

    task automatic test_mul();
        run_cmd(4'h1, 4'hD, 0);
        run_cmd(4'hB, 4'hB, 0);
        vectors++;
        if (uo_out !== 8'hAF || uio_out[7:4] !== 4'h8) begin
            miscompares++;
            $display("FAIL mul_d_b: got uo=%h hi=%h expected af 8", uo_out, uio_out[7:4]);
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(4'h1, 4'h3, 0);
        run_cmd(4'hB, 4'h5, 1);
        run_cmd(4'h1, 4'hF, 0);
        run_cmd(4'h2, 4'h1, 0);
        run_cmd(4'h9, 4'h0, 0);
        run_cmd(4'h9, 4'h7, 0);
        run_cmd(4'h7, 4'h0, 0);
        run_cmd(4'h8, 4'h0, 0);
        run_cmd(4'h4, 4'h6, 0);
        run_cmd(4'h5, 4'h9, 0);
        run_cmd(4'h6, 4'hF, 0);
        run_cmd(4'h1, 4'h9, 0);
        run_cmd(4'hB, 4'h7, 0);
        run_cmd(4'h1, 4'h2, 0);
        run_cmd(4'h0, 4'h5, 0);
        run_cmd(4'hC, 4'h0, 0);
        run_cmd(4'h1, 4'h8, 0);
        run_cmd(4'h3, 4'h1, 0);
    endtask

    task automatic test_reset_mid_mul();
        run_cmd(4'h1, 4'h6, 0);
        @(negedge clk);
        ui_in = 8'hB3;
        uio_in[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); @(negedge clk);
        end
        vectors++;
        if (uio_out[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_mul_busy: got %b expected 1", uio_out[1]);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_abort: got uo=%h uio=%h expected 00 00", uo_out, uio_out);
        end
        m_acc = 0; m_hi = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (uio_out !== 8'h00 || uo_out !== 8'h00) begin
                miscompares++;
                $display("FAIL held_strobe k=%0d: got uo=%h uio=%h expected 00 00", k, uo_out, uio_out);
            end
        end
        uio_in[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reserved();
        run_cmd(4'h1, 4'h7, 0);
        run_cmd(4'hE, 4'h3, 0);
        vectors++;
        if (uo_out !== 8'h07) begin
            miscompares++;
            $display("FAIL reserved_nop: got %h expected 07", uo_out);
        end
        run_cmd(4'hF, 4'hA, 0);
        run_cmd(4'hD, 4'h1, 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_sbc();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_reserved();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tt_um_4_bit_alu_exec.md
TT_UM_4_BIT_ALU_EXEC -- requirements
Module: tt_um_4_bit_alu_exec

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ena, input, 1 bit: always 1; functionally ignored.
REQ-004 SHALL have port ui_in, input, 8 bits: command word, opcode = ui_in[7:4], imm = ui_in[3:0].
REQ-005 SHALL have port uio_in, input, 8 bits: uio_in[0] = cmd_strobe (asynchronous); bits [7:1] unused.
REQ-006 SHALL have port uo_out, output, 8 bits: {C, Z, N, V, acc[3:0]}.
REQ-007 SHALL have port uio_out, output, 8 bits:
  - [7:4] = mul_hi
  - [2] = done
  - [1] = busy
  - [3], [0] = 0
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 8'hF6.

Function
REQ-009 SHALL pass cmd_strobe through a 2-flop synchronizer, then a rising-edge detector; a detected edge is an "accept".
REQ-010 SHALL honour an accept only in IDLE, latching opcode and imm from ui_in in that same cycle; an accept while busy SHALL be dropped.
REQ-011 SHALL implement FSM states IDLE, EXEC, MUL, DONE:
  - IDLE -> EXEC on accept.
  - EXEC -> MUL if opcode = 4'hB, else EXEC -> DONE.
  - MUL -> DONE after exactly 4 MUL cycles.
  - DONE -> IDLE unconditionally.
REQ-012 SHALL drive busy = (state != IDLE) and done = (state == DONE), with done high for exactly one cycle.
REQ-013 SHALL give non-MUL ops a latency of 2 cycles from accept to done; acc and flags SHALL update at the end of EXEC.
REQ-014 SHALL give MUL a latency of 6 cycles from accept to done; acc and mul_hi SHALL update at the end of the last MUL cycle.
REQ-015 SHALL decode opcodes as follows:
  - 0 NOP
  - 1 LOAD acc = imm
  - 2 ADD acc + imm
  - 3 SUB acc - imm
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 SHL by 1
  - 8 SHR (logical) by 1
  - 9 ADC acc + imm + C
  - A SBC acc - imm - !C
  - B MUL {mul_hi, acc} = acc * imm (unsigned, shift-add, one bit per cycle)
  - C CLR acc = 0, mul_hi = 0
  - D-F reserved, behave as NOP
REQ-016 SHALL truncate all results to 4 bits; arithmetic SHALL wrap modulo 16.
REQ-017 SHALL set Z = (result == 0) and N = result[3] for every op except NOP and reserved opcodes.
REQ-018 SHALL set C as follows:
  - ADD/ADC: carry-out.
  - SUB/SBC: no-borrow (1 when acc >= subtrahend).
  - SHL: old acc[3].
  - SHR: old acc[0].
  - MUL: (mul_hi != 0).
  - LOAD/CLR/logic ops: 0.
REQ-019 SHALL set V = two's-complement overflow for ADD/SUB/ADC/SBC, and V = 0 for all other flag-updating ops.
REQ-020 SHALL leave acc, mul_hi and all flags unchanged for NOP and reserved opcodes; these still pass through EXEC and DONE.
REQ-021 SHALL leave mul_hi unchanged by every op except MUL and CLR.
REQ-022 SHALL keep MUL's operand registers internal, so ui_in may change after accept without affecting the result.

Reset
REQ-023 SHALL, on rst_n low, immediately clear: state to IDLE, acc, mul_hi, C/Z/N/V, synchronizer and edge-detector flops, and latched opcode/imm.
REQ-024 SHALL show uo_out = 8'h00 and uio_out = 8'h00 while in reset.
REQ-025 SHALL abort any in-flight op when reset asserts mid-operation, with no partial result retained.
REQ-026 SHALL NOT generate an accept in the first cycle after reset release when cmd_strobe is already high; an accept requires a fresh 0->1 transition.

Structure
REQ-027 SHALL place the opcode localparams, FSM state encoding and the flag bit positions in shared package alu_pkg.
REQ-028 SHALL implement the shift-add multiplier as one sub-module, alu_mul4: start/done handshake, 4-cycle iteration, 8-bit product.
REQ-029 SHALL keep all other logic (synchronizer, FSM, datapath) in the top module; total RTL SHALL be approximately 150-250 lines.

Verification
REQ-030 SHALL cover: reset, LOAD 5 then ADD 4 -> acc = 9, N = 1, V = 1, C = 0, Z = 0; done exactly 2 cycles after accept.
REQ-031 SHALL cover: acc = 3, SUB 3 -> acc = 0, Z = 1, C = 1; then SBC 1 -> acc = 4'hF, N = 1, C = 0.
REQ-032 SHALL cover: LOAD 4'hD, MUL 4'hB -> {mul_hi, acc} = 8'h8F, C = 1, busy high for 6 cycles, done at accept + 6.
REQ-033 SHALL cover: second strobe edge issued during MUL -> dropped; acc/mul_hi reflect only the first op; no extra done pulse.
REQ-034 SHALL cover: rst_n asserted in MUL cycle 2 -> uo_out = 8'h00 and uio_out = 8'h00 immediately; strobe held high across release -> no accept.
REQ-035 SHALL cover: reserved opcode 4'hE after LOAD 7 -> uo_out unchanged (8'h07), one done pulse, 2-cycle latency.
